mem_access_unit: RTL and testbench

//  Parametrised load/store unit between the CPU datapath and the MIO bus.

---
 rtl/mau_pkg.sv | 44 ++++
 rtl/mau_lane_align.sv | 65 ++++++
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared size encodings, FSM states and byte-enable helpers for the memory access unit.
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned MAX_BE_W = 8;

  // 2^size contiguous ones starting at byte lane 'offset' (up to an 8-lane bus)
  function automatic logic [MAX_BE_W-1:0] be_mask(input logic [1:0] size,
                                                  input logic [2:0] offset);
    logic [MAX_BE_W-1:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  // Address bits that must be zero for an access of this size to be aligned
  function automatic logic [2:0] lo_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_BYTE: m = 3'b000;
      SZ_HALF: m = 3'b001;
      SZ_WORD: m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: store replication, byte enables and load extract/extend.
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]                    st_size,
  input  logic [$clog2(DATA_W/8)-1:0]   st_off,
  input  logic [DATA_W-1:0]             st_wdata,
  output logic [DATA_W/8-1:0]           st_be_c,
  output logic [DATA_W-1:0]             st_wdata_c,
  input  logic [1:0]                    ld_size,
  input  logic [$clog2(DATA_W/8)-1:0]   ld_off,
  input  logic                          ld_signed,
  input  logic [DATA_W-1:0]             ld_data,
  output logic [DATA_W-1:0]             ld_rdata_c
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sign_bit;

  assign st_be_c = BE_W'(be_mask(st_size, 3'(st_off)));

  // Store data is copied into every lane of its size so any offset sees it
  always_comb begin
    st_wdata_c = st_wdata;
    case (st_size)
      SZ_BYTE: st_wdata_c = {BE_W{st_wdata[7:0]}};
      SZ_HALF: st_wdata_c = {(DATA_W/16){st_wdata[15:0]}};
      SZ_WORD: st_wdata_c = {(DATA_W/32){st_wdata[31:0]}};
      default: st_wdata_c = st_wdata;
    endcase
  end

  assign shifted = ld_data >> {ld_off, 3'b000};

  always_comb begin
    keep     = '1;
    sign_bit = shifted[DATA_W-1];
    case (ld_size)
      SZ_BYTE: begin
        keep     = DATA_W'(8'hFF);
        sign_bit = shifted[7];
      end
      SZ_HALF: begin
        keep     = DATA_W'(16'hFFFF);
        sign_bit = shifted[15];
      end
      SZ_WORD: begin
        keep     = DATA_W'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: begin
        keep     = '1;
        sign_bit = shifted[DATA_W-1];
      end
    endcase
  end

  assign ld_rdata_c = (shifted & keep) | ((ld_signed && sign_bit) ? ~keep : '0);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: request handshake, MIO bus cycle with wait timeout, response pulse.
// Optional misalignment trap enabled by defining LSU_MISALIGN_EXC_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     data2CPU,
  input  logic                  MIO_ready
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [1:0]         q_size, q_size_d;
  logic               q_signed, q_signed_d;
  logic [OFF_W-1:0]   q_off, q_off_d;

  logic               req_ready_d;
  logic               rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_d;
  logic               rsp_err_d;
  logic               mem_req_d;
  logic               mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [BE_W-1:0]    mem_be_d;
  logic [DATA_W-1:0]  mem_wdata_d;
  logic               bus_done;

  logic [OFF_W-1:0]   req_off_c;
  logic [OFF_W-1:0]   lo_c;
  logic [OFF_W-1:0]   req_off_al_c;
  logic               size_bad_c;
  logic [BE_W-1:0]    st_be_c;
  logic [DATA_W-1:0]  st_wdata_c;
  logic [DATA_W-1:0]  ld_rdata_c;

  assign req_off_c    = req_addr[OFF_W-1:0];
  assign lo_c         = OFF_W'(lo_mask(req_size));
  assign req_off_al_c = req_off_c & ~lo_c;
  assign size_bad_c   = (req_size == SZ_DWORD) && (DATA_W < 64);

`ifdef LSU_MISALIGN_EXC_EN
  logic rsp_mis_d;
  logic mis_c;
  assign mis_c = |(req_off_c & lo_c);
`endif

  mau_lane_align #(.DATA_W(DATA_W)) u_lane (
    .st_size    (req_size),
    .st_off     (req_off_al_c),
    .st_wdata   (req_wdata),
    .st_be_c    (st_be_c),
    .st_wdata_c (st_wdata_c),
    .ld_size    (q_size),
    .ld_off     (q_off),
    .ld_signed  (q_signed),
    .ld_data    (data2CPU),
    .ld_rdata_c (ld_rdata_c)
  );

  // Next state, next registered outputs
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    q_size_d    = q_size;
    q_signed_d  = q_signed;
    q_off_d     = q_off;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    bus_done    = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    rsp_mis_d   = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (size_bad_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
`ifdef LSU_MISALIGN_EXC_EN
          else if (mis_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_mis_d   = 1'b1;
          end
`endif
          else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            q_size_d    = req_size;
            q_signed_d  = req_signed;
            q_off_d     = req_off_al_c;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be_d    = st_be_c;
            mem_wdata_d = st_wdata_c;
          end
        end
      end
      ST_BUS: begin
        // Completion takes priority over a timeout in the same cycle
        if (MIO_ready) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_we ? '0 : ld_rdata_c;
          bus_done    = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          bus_done    = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus_done) begin
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_be_d    = '0;
      mem_wdata_d = '0;
    end

    req_ready_d = (state_d == ST_IDLE);
  end

  // State, request and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      q_size    <= 2'b00;
      q_signed  <= 1'b0;
      q_off     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      q_size    <= q_size_d;
      q_signed  <= q_signed_d;
      q_off     <= q_off_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_misalign <= 1'b0;
    end else begin
      rsp_misalign <= rsp_mis_d;
    end
  end
`else
  assign rsp_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32, TIMEOUT=4) with a response scoreboard.
module tb_mem_access_unit;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned BE_W    = DATA_W / 8;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_misalign;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] data2CPU;
  logic              MIO_ready;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    int          waits;
  } ld_vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .rsp_misalign (rsp_misalign),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .data2CPU     (data2CPU),
    .MIO_ready    (MIO_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic push(input logic [31:0] rdata, input logic err, input logic mis);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.mis   = mis;
    sb.push_back(e);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, ".sb_pending"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".rdata"}, 64'(rsp_rdata), 64'(e.rdata));
      chk({tag, ".err"}, 64'(rsp_err), 64'(e.err));
      chk({tag, ".misalign"}, 64'(rsp_misalign), 64'(e.mis));
    end
  endtask

  task automatic finish_rsp(input string tag);
    tick();
    chk({tag, ".pulse_end"}, 64'(rsp_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(req_ready), 64'd1);
  endtask

  task automatic bus_done(input string tag, input int waits, input logic [31:0] rd);
    MIO_ready = 1'b0;
    repeat (waits) tick();
    data2CPU  = rd;
    MIO_ready = 1'b1;
    tick();
    MIO_ready = 1'b0;
    check_rsp(tag);
    finish_rsp(tag);
  endtask

  ld_vec_t lv[5];
  int      hi;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; data2CPU = '0; MIO_ready = 1'b0;
    repeat (3) tick();
    chk("reset.req_ready", 64'(req_ready), 64'd1);
    chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset.mem_req", 64'(mem_req), 64'd0);
    chk("reset.mem_be", 64'(mem_be), 64'd0);
    chk("reset.rsp_rdata", 64'(rsp_rdata), 64'd0);
    reset = 1'b0;
    tick();

    // Signed byte load from lane 3
    push(32'hFFFF_FF80, 1'b0, 1'b0);
    send(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0);
    chk("t1.mem_req", 64'(mem_req), 64'd1);
    chk("t1.mem_addr", 64'(mem_addr), 64'h100);
    chk("t1.mem_be", 64'(mem_be), 64'b1000);
    chk("t1.mem_we", 64'(mem_we), 64'd0);
    chk("t1.req_ready", 64'(req_ready), 64'd0);
    bus_done("t1", 0, 32'h80FF_1234);

    // Half store at offset 2, with an ignored request while busy
    push(32'h0, 1'b0, 1'b0);
    send(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_ABCD);
    chk("t2.mem_be", 64'(mem_be), 64'b1100);
    chk("t2.mem_wdata", 64'(mem_wdata), 64'hABCD_ABCD);
    chk("t2.mem_we", 64'(mem_we), 64'd1);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_addr = 32'h400;
    tick();
    req_valid = 1'b0;
    chk("t2.busy_addr", 64'(mem_addr), 64'h0);
    chk("t2.busy_be", 64'(mem_be), 64'b1100);
    chk("t2.busy_wdata", 64'(mem_wdata), 64'hABCD_ABCD);
    chk("t2.busy_req", 64'(mem_req), 64'd1);
    chk("t2.busy_ready", 64'(req_ready), 64'd0);
    chk("t2.busy_rsp", 64'(rsp_valid), 64'd0);
    bus_done("t2", 0, 32'h0);

    // Byte store replicates into all lanes
    push(32'h0, 1'b0, 1'b0);
    send(1'b1, 2'd0, 1'b0, 32'h0000_0043, 32'h0000_005A);
    chk("t2b.mem_be", 64'(mem_be), 64'b1000);
    chk("t2b.mem_wdata", 64'(mem_wdata), 64'h5A5A_5A5A);
    chk("t2b.mem_addr", 64'(mem_addr), 64'h40);
    bus_done("t2b", 1, 32'hFFFF_FFFF);

    // Load extract/extend table; last wait of 3 makes ready meet the timeout cycle
    lv[0] = '{2'd1, 1'b0, 32'h2, 32'h8001_1234, 32'h0000_8001, 4'b1100, 32'h0, 1};
    lv[1] = '{2'd1, 1'b1, 32'h0, 32'h1234_F00F, 32'hFFFF_F00F, 4'b0011, 32'h0, 2};
    lv[2] = '{2'd0, 1'b0, 32'h1, 32'h0000_9A00, 32'h0000_009A, 4'b0010, 32'h0, 0};
    lv[3] = '{2'd0, 1'b1, 32'h22, 32'h007F_0000, 32'h0000_007F, 4'b0100, 32'h20, 0};
    lv[4] = '{2'd2, 1'b1, 32'h8, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'b1111, 32'h8, 3};
    for (int i = 0; i < 5; i++) begin
      push(lv[i].exp_rdata, 1'b0, 1'b0);
      send(1'b0, lv[i].size, lv[i].sgn, lv[i].addr, 32'h0);
      chk($sformatf("ld%0d.mem_be", i), 64'(mem_be), 64'(lv[i].exp_be));
      chk($sformatf("ld%0d.mem_addr", i), 64'(mem_addr), 64'(lv[i].exp_addr));
      bus_done($sformatf("ld%0d", i), lv[i].waits, lv[i].data);
    end

    // Bus timeout
    push(32'h0, 1'b1, 1'b0);
    send(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
    MIO_ready = 1'b0;
    data2CPU  = 32'h1111_1111;
    hi = 0;
    while (mem_req === 1'b1 && hi < 10) begin
      hi++;
      tick();
    end
    chk("t3.req_cycles", 64'(hi), 64'(TIMEOUT));
    check_rsp("t3");
    finish_rsp("t3");

    // Illegal dword on a 32-bit bus
    push(32'h0, 1'b1, 1'b0);
    send(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    chk("t4.mem_req", 64'(mem_req), 64'd0);
    check_rsp("t4");
    finish_rsp("t4");

    // Misaligned word load at 0x6
`ifdef LSU_MISALIGN_EXC_EN
    push(32'h0, 1'b0, 1'b1);
    send(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0);
    chk("t5.mem_req", 64'(mem_req), 64'd0);
    check_rsp("t5");
    finish_rsp("t5");
`else
    push(32'hDEAD_BEEF, 1'b0, 1'b0);
    send(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0);
    chk("t5.mem_addr", 64'(mem_addr), 64'h4);
    chk("t5.mem_be", 64'(mem_be), 64'b1111);
    bus_done("t5", 0, 32'hDEAD_BEEF);
`endif

    // Reset during a bus cycle
    send(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0);
    chk("t6.mem_req_before", 64'(mem_req), 64'd1);
    reset = 1'b1;
    tick();
    chk("t6.mem_req", 64'(mem_req), 64'd0);
    chk("t6.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6.req_ready", 64'(req_ready), 64'd1);
    reset     = 1'b0;
    MIO_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("t6.no_rsp%0d", i), 64'(rsp_valid), 64'd0);
    end
    MIO_ready = 1'b0;

    chk("sb.empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
